// File: rtl/result_wb_ctrl_if.sv
// Write port of the output BRAM: address, enable, per-lane write enables and packed data.
interface result_wb_ctrl_if #(
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned N_MACS = 4,
    parameter int unsigned AW     = 8
);
    logic [AW-1:0]           bram_addr;
    logic                    bram_en;
    logic [N_MACS-1:0]       bram_we;
    logic [N_MACS*ACC_W-1:0] bram_din;

    modport master (output bram_addr, output bram_en, output bram_we, output bram_din);
    modport slave  (input bram_addr, input bram_en, input bram_we, input bram_din);
endinterface

// File: rtl/result_wb_ctrl.sv
// Result write-back controller: collects per-lane accumulator results, packs them into one
// BRAM word and writes NUM_WORDS words at consecutive addresses from a latched base.
module result_wb_ctrl #(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned N_MACS    = 4,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned NUM_WORDS = 4,
    localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic              flush,
    input  logic [ACC_W-1:0]  acc_in_0,
    input  logic [ACC_W-1:0]  acc_in_1,
    input  logic [ACC_W-1:0]  acc_in_2,
    input  logic [ACC_W-1:0]  acc_in_3,
    input  logic [N_MACS-1:0] valid_in,
    result_wb_ctrl_if.master  bram,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(MEM_DEPTH);
    localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e                  state_q, state_d;
    logic [N_MACS-1:0]       pending_q, pending_d;
    logic [ACC_W-1:0]        buf_q [N_MACS];
    logic [ACC_W-1:0]        buf_d [N_MACS];
    logic [AW-1:0]           base_q, base_d;
    logic [AW-1:0]           cnt_q, cnt_d;
    logic [N_MACS*ACC_W-1:0] din_q, din_d;
    logic                    overrun_q, overrun_d;

    logic [ACC_W-1:0]        acc_lane [N_MACS];
    logic [N_MACS*ACC_W-1:0] word;
    logic [AW:0]             addr_sum;
    logic                    fire;

    assign acc_lane[0] = acc_in_0;
    assign acc_lane[1] = acc_in_1;
    assign acc_lane[2] = acc_in_2;
    assign acc_lane[3] = acc_in_3;

    // Fire is decided on registered pending bits; captures in the fire cycle start the next word.
    assign fire = (state_q == StCollect) && ((&pending_q) || (flush && (|pending_q)));

    // Pack pending lanes, lane 0 in the LSBs; lanes not pending are driven as zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_MACS; i++) begin
            if (pending_q[i]) word[i*ACC_W +: ACC_W] = buf_q[i];
        end
    end

    // Write address wraps modulo MEM_DEPTH, also for non power-of-two depths.
    always_comb begin
        addr_sum = {1'b0, base_q} + {1'b0, cnt_q};
        if (addr_sum >= DEPTH_EXT) addr_sum = addr_sum - DEPTH_EXT;
    end

    assign bram.bram_addr = addr_sum[AW-1:0];
    assign bram.bram_en   = fire;
    assign bram.bram_we   = fire ? pending_q : '0;
    assign bram.bram_din  = fire ? word : din_q;
    assign busy           = (state_q == StCollect);
    assign done           = (state_q == StDone);
    assign overrun        = overrun_q;

    // Next-state logic: run control, lane capture, overrun detection and word commit.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        buf_d     = buf_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        din_d     = din_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StCollect;
                    base_d    = base_addr;
                    cnt_d     = '0;
                    pending_d = '0;
                    overrun_d = 1'b0;
                end
            end
            StCollect: begin
                if (fire) pending_d = '0;
                for (int i = 0; i < N_MACS; i++) begin
                    if (valid_in[i]) begin
                        if (!pending_q[i] || fire) begin
                            buf_d[i]     = acc_lane[i];
                            pending_d[i] = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                if (fire) begin
                    din_d = word;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            din_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N_MACS; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            din_q     <= din_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: tb/tb_result_wb_ctrl.sv
// Self-checking bench for result_wb_ctrl: vector table, corner-case sequences, random vs model.
module tb_result_wb_ctrl;

    localparam int NW = 4;

    logic        clk, rst, start, flush;
    logic [7:0]  base_addr;
    logic [3:0]  valid_in;
    logic [15:0] a0, a1, a2, a3;
    logic        busy, done, overrun;
    int          total = 0;
    int          bad = 0;

    result_wb_ctrl_if #(.ACC_W(16), .N_MACS(4), .AW(8)) bif ();

    result_wb_ctrl #(.ACC_W(16), .N_MACS(4), .MEM_DEPTH(256), .NUM_WORDS(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .flush(flush),
        .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3), .valid_in(valid_in),
        .bram(bif), .busy(busy), .done(done), .overrun(overrun)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        start;
        logic [7:0]  base;
        logic        flush;
        logic [3:0]  valid;
        logic [15:0] l0, l1, l2, l3;
        logic        en;
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [63:0] din;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic s, logic [7:0] b, logic f, logic [3:0] v,
                                logic [15:0] x0, logic [15:0] x1, logic [15:0] x2,
                                logic [15:0] x3, logic e, logic [3:0] w, logic [7:0] ad,
                                logic [63:0] d, logic bs, logic dn);
        vec_t r;
        r.start = s; r.base = b; r.flush = f; r.valid = v;
        r.l0 = x0; r.l1 = x1; r.l2 = x2; r.l3 = x3;
        r.en = e; r.we = w; r.addr = ad; r.din = d; r.busy = bs; r.done = dn;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [3:0] we,
                           input logic [7:0] addr, input logic [63:0] din, input logic bs,
                           input logic dn, input logic ov);
        chk({tag, ".en"}, 64'(bif.bram_en), 64'(en));
        chk({tag, ".we"}, 64'(bif.bram_we), 64'(we));
        chk({tag, ".addr"}, 64'(bif.bram_addr), 64'(addr));
        chk({tag, ".din"}, bif.bram_din, din);
        chk({tag, ".busy"}, 64'(busy), 64'(bs));
        chk({tag, ".done"}, 64'(done), 64'(dn));
        chk({tag, ".overrun"}, 64'(overrun), 64'(ov));
    endtask

    task automatic settle(); @(negedge clk); endtask
    task automatic next(); @(posedge clk); #1; endtask

    task automatic set_in(logic s, logic [7:0] b, logic f, logic [3:0] v, logic [15:0] x0,
                          logic [15:0] x1, logic [15:0] x2, logic [15:0] x3);
        start = s; base_addr = b; flush = f; valid_in = v;
        a0 = x0; a1 = x1; a2 = x2; a3 = x3;
    endtask

    // Reference model: a run is a sequence of words; a lane slot is either free or holds a value.
    bit          m_run, m_done;
    int          m_base, m_words;
    bit          m_has [4];
    logic [15:0] m_val [4];
    logic [63:0] m_last;
    bit          m_over;
    bit          p_en;
    logic [3:0]  p_we;
    logic [63:0] p_din;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_base = 0; m_words = 0; m_last = '0; m_over = 0;
        for (int i = 0; i < 4; i++) begin m_has[i] = 0; m_val[i] = '0; end
    endtask

    task automatic model_predict();
        int n = 0;
        logic [63:0] w = '0;
        for (int i = 0; i < 4; i++) if (m_has[i]) begin n++; w = w | (64'(m_val[i]) << (16*i)); end
        p_en = m_run && (n == 4 || (flush && n > 0));
        p_we = '0;
        for (int i = 0; i < 4; i++) if (p_en && m_has[i]) p_we[i] = 1'b1;
        p_din = p_en ? w : m_last;
    endtask

    task automatic model_step();
        logic [15:0] lanes [4];
        lanes[0] = a0; lanes[1] = a1; lanes[2] = a2; lanes[3] = a3;
        if (m_done) begin
            m_done = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_base = int'(base_addr); m_words = 0; m_over = 0;
                for (int i = 0; i < 4; i++) m_has[i] = 0;
            end
        end else begin
            if (p_en) begin
                m_last = p_din;
                for (int i = 0; i < 4; i++) m_has[i] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (valid_in[i]) begin
                    if (!m_has[i]) begin m_has[i] = 1; m_val[i] = lanes[i]; end
                    else m_over = 1;
                end
            end
            if (p_en) begin
                m_words++;
                if (m_words == NW) begin m_run = 0; m_done = 1; end
            end
        end
    endtask

    initial begin
        logic [63:0] d1, d2, d3, d4, exp_w;
        rst = 0;
        set_in(0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
        settle();
        chk_out("reset", 0, 4'h0, 8'h00, 64'h0, 0, 0, 0);
        next();
        rst = 1;

        // Basic run, staggered lanes, partial flush, final word, start ignored in DONE.
        d1 = 64'h0004_0003_0002_0001;
        d2 = 64'h0044_0033_0022_0011;
        d3 = 64'h0000_0000_8000_7FFF;
        d4 = 64'h0008_0007_0006_0005;
        vecs[0]  = mk(1, 8'h10, 0, 4'h0, 0, 0, 0, 0,                1, 4'h0, 8'h00, 64'h0, 0, 0);
        vecs[0].en = 0;
        vecs[1]  = mk(0, 8'h00, 0, 4'hF, 1, 2, 3, 4,                0, 4'h0, 8'h10, 64'h0, 1, 0);
        vecs[2]  = mk(0, 8'h00, 0, 4'h0, 0, 0, 0, 0,                1, 4'hF, 8'h10, d1, 1, 0);
        vecs[3]  = mk(0, 8'h00, 0, 4'h1, 16'h11, 0, 0, 0,           0, 4'h0, 8'h11, d1, 1, 0);
        vecs[4]  = mk(0, 8'h00, 0, 4'h2, 0, 16'h22, 0, 0,           0, 4'h0, 8'h11, d1, 1, 0);
        vecs[5]  = mk(0, 8'h00, 0, 4'h4, 0, 0, 16'h33, 0,           0, 4'h0, 8'h11, d1, 1, 0);
        vecs[6]  = mk(0, 8'h00, 0, 4'h8, 0, 0, 0, 16'h44,           0, 4'h0, 8'h11, d1, 1, 0);
        vecs[7]  = mk(0, 8'h00, 0, 4'h0, 0, 0, 0, 0,                1, 4'hF, 8'h11, d2, 1, 0);
        vecs[8]  = mk(0, 8'h00, 0, 4'h3, 16'h7FFF, 16'h8000, 0, 0, 0, 4'h0, 8'h12, d2, 1, 0);
        vecs[9]  = mk(0, 8'h00, 1, 4'h0, 0, 0, 0, 0,                1, 4'h3, 8'h12, d3, 1, 0);
        vecs[10] = mk(0, 8'h00, 0, 4'h0, 0, 0, 0, 0,                0, 4'h0, 8'h13, d3, 1, 0);
        vecs[11] = mk(0, 8'h00, 0, 4'hF, 5, 6, 7, 8,                0, 4'h0, 8'h13, d3, 1, 0);
        vecs[12] = mk(0, 8'h00, 0, 4'h0, 0, 0, 0, 0,                1, 4'hF, 8'h13, d4, 1, 0);
        vecs[13] = mk(1, 8'h80, 0, 4'hF, 9, 9, 9, 9,                0, 4'h0, 8'h14, d4, 0, 1);
        vecs[14] = mk(0, 8'h00, 0, 4'hF, 9, 9, 9, 9,                0, 4'h0, 8'h14, d4, 0, 0);
        for (int r = 0; r < 15; r++) begin
            set_in(vecs[r].start, vecs[r].base, vecs[r].flush, vecs[r].valid,
                   vecs[r].l0, vecs[r].l1, vecs[r].l2, vecs[r].l3);
            settle();
            chk_out($sformatf("vec%0d", r), vecs[r].en, vecs[r].we, vecs[r].addr, vecs[r].din,
                    vecs[r].busy, vecs[r].done, 0);
            next();
        end

        // Full run with address wrap, back-to-back words, done one cycle after last write.
        set_in(1, 8'hFE, 0, 4'h0, 0, 0, 0, 0);
        next();
        for (int k = 0; k < 7; k++) begin
            logic [7:0] ea;
            set_in(0, 8'h00, 0, (k < 4) ? 4'hF : 4'h0, 16'(k*4), 16'(k*4+1), 16'(k*4+2),
                   16'(k*4+3));
            settle();
            ea = 8'hFE + 8'(k - 1);
            exp_w = {16'((k-1)*4+3), 16'((k-1)*4+2), 16'((k-1)*4+1), 16'((k-1)*4)};
            if (k >= 1 && k <= 4)
                chk_out($sformatf("wrap%0d", k), 1, 4'hF, ea, exp_w, 1, 0, 0);
            else if (k == 5) begin
                chk("wrap_done", 64'(done), 64'd1);
                chk("wrap_busy_fall", 64'(busy), 64'd0);
                chk("wrap_no_en", 64'(bif.bram_en), 64'd0);
            end else if (k == 6)
                chk("wrap_done_pulse", 64'(done), 64'd0);
            next();
        end

        // Overrun: second lane-2 value dropped, first one written; start clears the flag.
        set_in(1, 8'h40, 0, 4'h0, 0, 0, 0, 0);
        next();
        set_in(0, 8'h00, 0, 4'h4, 0, 0, 5, 0);
        next();
        set_in(0, 8'h00, 0, 4'h4, 0, 0, 9, 0);
        settle();
        chk("ovr_not_yet", 64'(overrun), 64'd0);
        next();
        set_in(0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
        settle();
        chk("ovr_set", 64'(overrun), 64'd1);
        next();
        set_in(0, 8'h00, 0, 4'hB, 1, 2, 16'hEEEE, 3);
        next();
        set_in(0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
        settle();
        chk_out("ovr_word", 1, 4'hF, 8'h40, 64'h0003_0005_0002_0001, 1, 0, 1);
        next();
        flush = 1;
        settle();
        chk("flush_empty", 64'(bif.bram_en), 64'd0);
        next();
        flush = 0;
        for (int k = 0; k < 3; k++) begin valid_in = 4'hF; next(); end
        valid_in = 4'h0;
        next();
        settle();
        chk("ovr_run_done", 64'(done), 64'd1);
        next();
        settle();
        chk("ovr_sticky", 64'(overrun), 64'd1);
        start = 1; base_addr = 8'h20;
        next();
        start = 0;
        settle();
        chk("ovr_cleared", 64'(overrun), 64'd0);
        chk("ovr_busy", 64'(busy), 64'd1);

        // Reset mid-run with three lanes pending.
        next();
        set_in(0, 8'h00, 0, 4'h7, 16'hA, 16'hB, 16'hC, 0);
        next();
        valid_in = 4'h0;
        settle();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 0;
        #1;
        chk_out("mid_rst", 0, 4'h0, 8'h00, 64'h0, 0, 0, 0);
        next();
        rst = 1;
        set_in(0, 8'h00, 1, 4'hF, 1, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("post_rst_idle%0d", k), {62'h0, bif.bram_en, busy}, 64'h0);
            next();
        end
        set_in(1, 8'h30, 0, 4'h0, 0, 0, 0, 0);
        next();
        set_in(0, 8'h00, 0, 4'h1, 16'h55, 0, 0, 0);
        next();
        set_in(0, 8'h00, 1, 4'h0, 0, 0, 0, 0);
        settle();
        chk_out("post_rst_run", 1, 4'h1, 8'h30, 64'h55, 1, 0, 0);
        next();

        // Randomized traffic against the reference model.
        rst = 0;
        set_in(0, 8'h00, 0, 4'h0, 0, 0, 0, 0);
        next();
        rst = 1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
                   ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom),
                   16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            model_predict();
            settle();
            chk_out($sformatf("rnd%0d", c), p_en, p_we, 8'((m_base + m_words) % 256), p_din,
                    m_run, m_done, m_over);
            model_step();
            next();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
